// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU/MDU.
//   alu_op_e : 5-bit operation code (base ALU ops 0x00-0x0B, mul 0x10-0x13,
//              div/rem 0x14-0x17; every other code is undefined and gives 0).
//   state_e  : handshake FSM states.
//   fix_t    : sign/half selection captured at acceptance for multi-cycle ops.
//   is_muldiv: true for the 0x10-0x17 block.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'h00,
    OP_SLL    = 5'h01,
    OP_XOR    = 5'h02,
    OP_SRL    = 5'h03,
    OP_SRA    = 5'h04,
    OP_OR     = 5'h05,
    OP_AND    = 5'h06,
    OP_SUB    = 5'h07,
    OP_SLT    = 5'h08,
    OP_PASSB  = 5'h09,
    OP_PASSA  = 5'h0A,
    OP_SLTU   = 5'h0B,
    OP_MUL    = 5'h10,
    OP_MULH   = 5'h11,
    OP_MULHSU = 5'h12,
    OP_MULHU  = 5'h13,
    OP_DIV    = 5'h14,
    OP_DIVU   = 5'h15,
    OP_REM    = 5'h16,
    OP_REMU   = 5'h17
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic neg;  // negate the magnitude result
    logic hi;   // mul: take high half; div: take remainder
  } fix_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Shared XLEN-iteration datapath for unsigned shift-add multiply and
// restoring divide on operand magnitudes.
//   start     : load sreg_init/opd_init, clear accumulator and counter
//   en        : perform one iteration this cycle
//   div_mode  : 1 = restoring divide step, 0 = shift-add multiply step
//   clr       : discard the iteration count (abort)
//   acc_nxt / sreg_nxt : value after this cycle's step, so the caller can
//                        fold its sign fix-up into the last iteration
//   done      : this cycle performs the final (XLEN-th) iteration
// Multiply: acc = product high half, sreg = multiplier shifting out / low half.
// Divide  : acc = partial remainder, sreg = dividend shifting out / quotient.
module mul_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            start,
  input  logic            en,
  input  logic            div_mode,
  input  logic [XLEN-1:0] sreg_init,
  input  logic [XLEN-1:0] opd_init,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] sreg_nxt,
  output logic            done
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] acc, sreg, opd;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   mul_sum, div_sh, div_dif;

  assign mul_sum = {1'b0, acc} + (sreg[0] ? {1'b0, opd} : '0);
  assign div_sh  = {acc, sreg[XLEN-1]};
  assign div_dif = div_sh - {1'b0, opd};
  assign done    = en && (cnt == CW'(XLEN-1));

  always_comb begin
    acc_nxt  = mul_sum[XLEN:1];
    sreg_nxt = {mul_sum[0], sreg[XLEN-1:1]};
    if (div_mode) begin
      // Remainder never exceeds the divisor, so XLEN bits always suffice.
      if (!div_dif[XLEN]) begin
        acc_nxt  = div_dif[XLEN-1:0];
        sreg_nxt = {sreg[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt  = div_sh[XLEN-1:0];
        sreg_nxt = {sreg[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      sreg <= '0;
      opd  <= '0;
      cnt  <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (start) begin
      acc  <= '0;
      sreg <= sreg_init;
      opd  <= opd_init;
      cnt  <= '0;
    end else if (en) begin
      acc  <= acc_nxt;
      sreg <= sreg_nxt;
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mdu_alu.sv
// Execute-stage integer ALU with RV32M-style multiply/divide behind a
// valid/ready handshake.
//   clk, rst_n          : clock, async active-low reset
//   flush               : abort any in-flight op, drop the held result
//   in_valid/in_ready   : op/a/b issue handshake
//   op, a, b            : operation (alu_pkg::alu_op_e) and operands
//   out_valid/out_ready : result handshake; result is registered
//   busy                : multi-cycle iteration in progress
// Base ops and divide special cases finish in one cycle; mul/div take XLEN
// iterations plus the handshake cycle.
module mdu_alu
  import alu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  alu_op_e           op_e;
  state_e            state, state_nxt;
  fix_t              fix_q, fix_d;
  logic              accept, md_op, div_op, rem_sel, a_sgn, b_sgn, a_neg, b_neg;
  logic              div0, ovf, special, iter_start, iter_done;
  logic [XLEN-1:0]   a_mag, b_mag, imm_res, fix_res, acc_nxt, sreg_nxt, div_sel, div_fix;
  logic [2*XLEN-1:0] prod, prod_fix;

  assign op_e    = alu_op_e'(op);
  assign md_op   = is_muldiv(op);
  assign div_op  = md_op && op[2];
  assign rem_sel = div_op && op[1];

  // DONE behaves as idle for issue: a new op may enter while the held result
  // drains in the same cycle.
  assign in_ready  = !flush && (state == ST_IDLE || (state == ST_DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_MUL) || (state == ST_DIV);

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op_e)
      OP_MULH, OP_DIV, OP_REM: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      OP_MULHSU:               a_sgn = 1'b1;
      default:                 ;
    endcase
  end

  assign a_neg   = a_sgn && a[XLEN-1];
  assign b_neg   = b_sgn && b[XLEN-1];
  assign a_mag   = a_neg ? -a : a;
  assign b_mag   = b_neg ? -b : b;
  assign fix_d.neg = rem_sel ? a_neg : (a_neg ^ b_neg);
  assign fix_d.hi  = div_op ? op[1] : (op[1:0] != 2'b00);

  assign div0       = (b == '0);
  assign ovf        = a_sgn && (a == MOST_NEG) && (b == '1);
  assign special    = div_op && (div0 || ovf);
  assign iter_start = accept && md_op && !special;

  always_comb begin
    imm_res = '0;
    if (special) begin
      if (div0) imm_res = rem_sel ? a : '1;
      else      imm_res = rem_sel ? '0 : a;
    end else begin
      case (op_e)
        OP_ADD:   imm_res = a + b;
        OP_SUB:   imm_res = a - b;
        OP_XOR:   imm_res = a ^ b;
        OP_OR:    imm_res = a | b;
        OP_AND:   imm_res = a & b;
        OP_SLL:   imm_res = a << b[SHW-1:0];
        OP_SRL:   imm_res = a >> b[SHW-1:0];
        OP_SRA:   imm_res = $signed(a) >>> b[SHW-1:0];
        OP_SLT:   imm_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
        OP_SLTU:  imm_res = {{(XLEN-1){1'b0}}, a < b};
        OP_PASSA: imm_res = a;
        OP_PASSB: imm_res = b;
        default:  imm_res = '0;
      endcase
    end
  end

  mul_div_iter #(.XLEN(XLEN)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .start     (iter_start),
    .en        (busy),
    .div_mode  (state == ST_DIV),
    .sreg_init (div_op ? a_mag : b_mag),
    .opd_init  (div_op ? b_mag : a_mag),
    .acc_nxt   (acc_nxt),
    .sreg_nxt  (sreg_nxt),
    .done      (iter_done)
  );

  // Sign fix-up applied to the last iteration's output, so the result lands
  // on the same edge the FSM enters DONE.
  assign prod     = {acc_nxt, sreg_nxt};
  assign prod_fix = fix_q.neg ? -prod : prod;
  assign div_sel  = fix_q.hi ? acc_nxt : sreg_nxt;
  assign div_fix  = fix_q.neg ? -div_sel : div_sel;
  assign fix_res  = (state == ST_DIV) ? div_fix
                  : (fix_q.hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0]);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (md_op && !special) state_nxt = div_op ? ST_DIV : ST_MUL;
          else                   state_nxt = ST_DONE;
        end else if (state == ST_DONE && out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: if (iter_done) state_nxt = ST_DONE;
      default:        state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      result <= '0;
      fix_q  <= '0;
    end else begin
      state <= state_nxt;
      if (!flush) begin
        if (accept && !iter_start) result <= imm_res;
        else if (iter_done)        result <= fix_res;
        if (iter_start)            fix_q  <= fix_d;
      end
    end
  end

endmodule
